wam_gen: RTL and testbench

- Mole generator and lifetime tracker for Whac-A-Mole. Consumes the per-difficulty parameters `age` (mole lifetime in ticks) and `rto` (spawn ratio 0..255) from the hardness-parameter logic.
- Spawns moles pseudo-randomly into N holes and ages them on each game tick.
- Resolves debounced hole hits into hit/miss/whiff counts for the score logic.
- Sits between the hardness-parameter block and the display/score blocks.

---
 rtl/wam_pkg.sv | 24 ++
 rtl/wam_lfsr.sv | 21 ++
 rtl/wam_gen.sv | 118 +++++++++++
 tb/tb_wam_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared constants, hole event encoding and LFSR step function for the
// Whac-A-Mole mole generator.
package wam_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          DEFAULT_N    = 16;
  localparam int          DEFAULT_IW   = 4;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HIT,
    EV_WHIFF,
    EV_EXPIRE,
    EV_AGE,
    EV_SPAWN
  } hole_ev_t;

  // Galois right shift: the bit falling out of the LSB folds the tap mask back in.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// 16-bit Galois LFSR; steps once per cycle with adv, reloads SEED on clr.
module wam_lfsr
  import wam_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk_19,
  input  logic        clr,
  input  logic        adv,
  output logic [15:0] q
);

  always_ff @(posedge clk_19) begin
    if (clr) begin
      q <= SEED;
    end else if (adv) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/wam_gen.sv
// Mole spawner and lifetime tracker: spawns moles from an LFSR, ages them on
// game ticks and reports per-cycle hit, miss and whiff counts.
module wam_gen
  import wam_pkg::*;
#(
  parameter int          N    = DEFAULT_N,
  parameter int          IW   = DEFAULT_IW,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic          clk_19,
  input  logic          clr,
  input  logic          en,
  input  logic          tick,
  input  logic [3:0]    age,
  input  logic [7:0]    rto,
  input  logic [N-1:0]  hit,
  output logic [N-1:0]  mole,
  output logic [IW:0]   hit_n,
  output logic [IW:0]   miss_n,
  output logic [IW:0]   whf_n
);

  logic [15:0]   lfsr_q;
  logic [IW-1:0] slot;
  logic [7:0]    rbyte;
  logic          spawn_ok;
  logic [3:0]    age_eff;
  logic [N-1:0]  hit_v;
  logic [N-1:0]  whf_v;
  logic [N-1:0]  exp_v;
  logic          unused_lfsr_bits;

  wam_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_19 (clk_19),
    .clr    (clr),
    .adv    (en & tick),
    .q      (lfsr_q)
  );

  assign slot             = lfsr_q[IW-1:0];
  assign rbyte            = lfsr_q[15:8];
  assign unused_lfsr_bits = ^lfsr_q[7:IW];
  assign spawn_ok         = tick && (rbyte < rto);
  assign age_eff          = (age == 4'd0) ? 4'd1 : age;

  function automatic logic [IW:0] popcnt(input logic [N-1:0] v);
    logic [IW:0] c;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = c + {{IW{1'b0}}, v[k]};
    end
    return c;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_hole
    logic [3:0] life;
    logic       occ;
    hole_ev_t   ev;

    // Hits win over expiry/aging; a whack on an empty hole also blocks its spawn.
    always_comb begin
      ev = EV_NONE;
      if (hit[i] && occ) begin
        ev = EV_HIT;
      end else if (hit[i]) begin
        ev = EV_WHIFF;
      end else if (tick && occ && life == 4'd1) begin
        ev = EV_EXPIRE;
      end else if (tick && occ) begin
        ev = EV_AGE;
      end else if (spawn_ok && slot == IW'(i)) begin
        ev = EV_SPAWN;
      end
    end

    always_ff @(posedge clk_19) begin
      if (clr) begin
        life <= 4'd0;
        occ  <= 1'b0;
      end else if (en) begin
        case (ev)
          EV_HIT, EV_EXPIRE: begin
            life <= 4'd0;
            occ  <= 1'b0;
          end
          EV_AGE: begin
            life <= life - 4'd1;
          end
          EV_SPAWN: begin
            life <= age_eff;
            occ  <= 1'b1;
          end
          default: begin
            life <= life;
          end
        endcase
      end
    end

    assign mole[i]  = occ;
    assign hit_v[i] = (ev == EV_HIT);
    assign whf_v[i] = (ev == EV_WHIFF);
    assign exp_v[i] = (ev == EV_EXPIRE);
  end

  always_ff @(posedge clk_19) begin
    if (clr || !en) begin
      hit_n  <= '0;
      miss_n <= '0;
      whf_n  <= '0;
    end else begin
      hit_n  <= popcnt(hit_v);
      miss_n <= popcnt(exp_v);
      whf_n  <= popcnt(whf_v);
    end
  end

endmodule

// File: tb/tb_wam_gen.sv
// Directed self-checking bench for wam_gen: reset, lifetimes, hits, whiffs,
// spawn gating, freeze and mid-game clear.
module tb_wam_gen;

  logic        clk_19 = 1'b0;
  logic        clr    = 1'b0;
  logic        en     = 1'b0;
  logic        tick   = 1'b0;
  logic [3:0]  age    = 4'd0;
  logic [7:0]  rto    = 8'd0;
  logic [15:0] hit    = 16'h0000;
  logic [15:0] mole;
  logic [4:0]  hit_n;
  logic [4:0]  miss_n;
  logic [4:0]  whf_n;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_lfsr;

  wam_gen #(.N(16), .IW(4), .SEED(16'hACE1)) dut (
    .clk_19 (clk_19),
    .clr    (clr),
    .en     (en),
    .tick   (tick),
    .age    (age),
    .rto    (rto),
    .hit    (hit),
    .mole   (mole),
    .hit_n  (hit_n),
    .miss_n (miss_n),
    .whf_n  (whf_n)
  );

  always #5 clk_19 = ~clk_19;

  function automatic logic [15:0] lnext(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk_19);
    #1;
  endtask

  task automatic tick_once(input logic [7:0] r);
    rto  = r;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    m_lfsr = lnext(m_lfsr);
  endtask

  // Step with spawning disabled until the model LFSR points at the slot with a usable byte.
  task automatic advance_to(input logic [3:0] s, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (m_lfsr[3:0] == s && m_lfsr[15:8] != 8'hFF) ok = 1'b1;
      else tick_once(8'd0);
    end
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL advance_to: slot %0d not reached got 0 want 1", s); end
  endtask

  task automatic find_pair(output int k, output int j, output logic ok);
    logic [15:0] s, t;
    logic [3:0]  other;
    ok = 1'b0; k = 0; j = 0;
    s = m_lfsr;
    for (int a = 0; a < 3000 && !ok; a++) begin
      if ((s[3:0] == 4'd2 || s[3:0] == 4'd5) && s[15:8] != 8'hFF) begin
        other = (s[3:0] == 4'd2) ? 4'd5 : 4'd2;
        t = lnext(s);
        for (int b = 1; b <= 14 && !ok; b++) begin
          if (t[3:0] == other && t[15:8] != 8'hFF) begin ok = 1'b1; k = a; j = a + b; end
          t = lnext(t);
        end
      end
      s = lnext(s);
    end
  endtask

  task automatic test_reset();
    en = 1'b1; clr = 1'b1; tick = 1'b1; hit = 16'hFFFF;
    cycle();
    cycle();
    total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL reset_mole: got %h want 0000", mole); end
    total++; if (hit_n !== 5'd0) begin bad++; $display("[TB] FAIL reset_hit_n: got %0d want 0", hit_n); end
    total++; if (whf_n !== 5'd0) begin bad++; $display("[TB] FAIL reset_whf_n: got %0d want 0", whf_n); end
    total++; if (miss_n !== 5'd0) begin bad++; $display("[TB] FAIL reset_miss_n: got %0d want 0", miss_n); end
    total++; if (dut.u_lfsr.q !== 16'hACE1) begin bad++; $display("[TB] FAIL reset_lfsr: got %h want ACE1", dut.u_lfsr.q); end
    clr = 1'b0; tick = 1'b0; hit = 16'h0000;
    m_lfsr = 16'hACE1;
    tick_once(8'd0);
    total++; if (dut.u_lfsr.q !== 16'hE270) begin bad++; $display("[TB] FAIL first_tick_lfsr: got %h want E270", dut.u_lfsr.q); end
    total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL first_tick_mole: got %h want 0000", mole); end
  endtask

  task automatic test_lifetime();
    logic ok;
    age = 4'd3;
    advance_to(4'd1, ok);
    tick_once(8'd255);
    total++; if (mole !== 16'h0002) begin bad++; $display("[TB] FAIL life_spawn: got %h want 0002", mole); end
    tick_once(8'd0);
    tick_once(8'd0);
    total++; if (mole !== 16'h0002 || miss_n !== 5'd0) begin bad++; $display("[TB] FAIL life_tick2: got mole %h miss %0d want 0002 0", mole, miss_n); end
    tick_once(8'd0);
    total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL life_expire_mole: got %h want 0000", mole); end
    total++; if (miss_n !== 5'd1) begin bad++; $display("[TB] FAIL life_expire_miss: got %0d want 1", miss_n); end
    cycle();
    total++; if (miss_n !== 5'd0) begin bad++; $display("[TB] FAIL life_miss_pulse: got %0d want 0", miss_n); end
  endtask

  task automatic test_age_zero();
    logic ok;
    age = 4'd0;
    advance_to(4'd3, ok);
    tick_once(8'd255);
    total++; if (mole !== 16'h0008) begin bad++; $display("[TB] FAIL age0_spawn: got %h want 0008", mole); end
    tick_once(8'd0);
    total++; if (mole !== 16'h0000 || miss_n !== 5'd1) begin bad++; $display("[TB] FAIL age0_expire: got mole %h miss %0d want 0000 1", mole, miss_n); end
  endtask

  task automatic test_hit_vs_expiry();
    logic ok;
    age = 4'd1;
    advance_to(4'd4, ok);
    tick_once(8'd255);
    total++; if (mole !== 16'h0010) begin bad++; $display("[TB] FAIL hve_spawn: got %h want 0010", mole); end
    hit = 16'h0010;
    tick_once(8'd0);
    hit = 16'h0000;
    total++; if (hit_n !== 5'd1) begin bad++; $display("[TB] FAIL hve_hit_n: got %0d want 1", hit_n); end
    total++; if (miss_n !== 5'd0) begin bad++; $display("[TB] FAIL hve_miss_n: got %0d want 0", miss_n); end
    total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL hve_mole: got %h want 0000", mole); end
    cycle();
    total++; if (hit_n !== 5'd0) begin bad++; $display("[TB] FAIL hve_hit_pulse: got %0d want 0", hit_n); end
  endtask

  task automatic test_whiff_multi_hit();
    int k, j;
    logic ok;
    age = 4'd15;
    find_pair(k, j, ok);
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL whiff_setup: got 0 want 1");
    end else begin
      for (int idx = 0; idx <= j; idx++) tick_once((idx == k || idx == j) ? 8'd255 : 8'd0);
      total++; if (mole !== 16'h0024) begin bad++; $display("[TB] FAIL whiff_spawn: got %h want 0024", mole); end
      hit = 16'h0025;
      cycle();
      hit = 16'h0000;
      total++; if (hit_n !== 5'd2) begin bad++; $display("[TB] FAIL multi_hit_n: got %0d want 2", hit_n); end
      total++; if (whf_n !== 5'd1) begin bad++; $display("[TB] FAIL multi_whf_n: got %0d want 1", whf_n); end
      total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL multi_mole: got %h want 0000", mole); end
    end
  endtask

  task automatic test_spawn_control();
    logic [15:0] mask;
    logic [15:0] held;
    for (int n = 0; n < 200; n++) tick_once(8'd0);
    total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL rto0_mole: got %h want 0000", mole); end
    total++; if (dut.u_lfsr.q !== m_lfsr) begin bad++; $display("[TB] FAIL rto0_lfsr: got %h want %h", dut.u_lfsr.q, m_lfsr); end
    age = 4'd15;
    mask = 16'h0000;
    for (int n = 0; n < 12 && $countones(mask) < 3; n++) begin
      if (m_lfsr[15:8] != 8'hFF) mask[m_lfsr[3:0]] = 1'b1;
      tick_once(8'd255);
    end
    total++; if (mole !== mask) begin bad++; $display("[TB] FAIL spawn3_mole: got %h want %h", mole, mask); end
    held = m_lfsr;
    en = 1'b0; tick = 1'b1; hit = 16'hFFFF; rto = 8'd255;
    for (int n = 0; n < 5; n++) cycle();
    total++; if (mole !== mask) begin bad++; $display("[TB] FAIL freeze_mole: got %h want %h", mole, mask); end
    total++; if (dut.u_lfsr.q !== held) begin bad++; $display("[TB] FAIL freeze_lfsr: got %h want %h", dut.u_lfsr.q, held); end
    total++; if (hit_n !== 5'd0 || whf_n !== 5'd0 || miss_n !== 5'd0) begin bad++; $display("[TB] FAIL freeze_counts: got %0d/%0d/%0d want 0/0/0", hit_n, whf_n, miss_n); end
    en = 1'b1; clr = 1'b1;
    cycle();
    clr = 1'b0; tick = 1'b0; hit = 16'h0000; rto = 8'd0;
    total++; if (mole !== 16'h0000) begin bad++; $display("[TB] FAIL clr_mole: got %h want 0000", mole); end
    total++; if (hit_n !== 5'd0 || whf_n !== 5'd0 || miss_n !== 5'd0) begin bad++; $display("[TB] FAIL clr_counts: got %0d/%0d/%0d want 0/0/0", hit_n, whf_n, miss_n); end
    total++; if (dut.u_lfsr.q !== 16'hACE1) begin bad++; $display("[TB] FAIL clr_lfsr: got %h want ACE1", dut.u_lfsr.q); end
    cycle();
    total++; if (hit_n !== 5'd0 || whf_n !== 5'd0 || miss_n !== 5'd0) begin bad++; $display("[TB] FAIL post_clr_counts: got %0d/%0d/%0d want 0/0/0", hit_n, whf_n, miss_n); end
  endtask

  initial begin
    $display("[TB] starting wam_gen bench");
    test_reset();
    test_lifetime();
    test_age_zero();
    test_hit_vs_expiry();
    test_whiff_multi_hit();
    test_spawn_control();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
